// File: rtl/ss_map_sequencer_pkg.sv
// Shared types and constants for the map-segment sequencer and the map mux.
// The sequencer FSM states, the map index encoding and the map_sel width
// live here so the mux and the controller never disagree on encoding.
package ss_map_pkg;

    // Width of the map selector driven into the map ROM mux.
    typedef logic [1:0] map_sel_t;

    // Map segment indices.
    localparam map_sel_t MAP_PART1 = 2'd0;
    localparam map_sel_t MAP_LR    = 2'd1;
    localparam map_sel_t MAP_LOOP  = 2'd2;

    // Sequencer states.
    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        BLANK    = 2'd1,
        WRAP     = 2'd2,
        DISARMED = 2'd3
    } state_t;

    // Limit a raw switch value to a valid map index.
    function automatic map_sel_t clamp_map(input logic [1:0] raw, input int num_maps);
        if (int'(raw) >= num_maps) begin
            return map_sel_t'(num_maps - 1);
        end
        return raw;
    endfunction

endpackage

// File: rtl/ss_map_sequencer_if.sv
// Bus between player-position logic (master) and the map sequencer (slave).
// Handshake: wrap_req is raised by the sequencer and held high until it
// samples wrap_ack high on a rising clk_75 edge; that edge completes the
// transfer and wrap_req drops on the following cycle. wrap_ack seen while
// wrap_req is low has no effect.
interface ss_map_sequencer_if;
    import ss_map_pkg::*;

    logic        frame_tick;
    logic [7:0]  LocX;
    logic        loc_valid;
    logic        wrap_ack;
    logic [15:0] debounced_SW_75;
    map_sel_t    map_sel;
    logic        map_changing;
    logic        wrap_req;
    logic        wrap_dir;
    logic        loop_active;

    // Player / video side.
    modport master (
        output frame_tick, LocX, loc_valid, wrap_ack, debounced_SW_75,
        input  map_sel, map_changing, wrap_req, wrap_dir, loop_active
    );

    // Sequencer side.
    modport slave (
        input  frame_tick, LocX, loc_valid, wrap_ack, debounced_SW_75,
        output map_sel, map_changing, wrap_req, wrap_dir, loop_active
    );
endinterface

// File: rtl/ss_map_sequencer_blank_timer.sv
// Frame-counting down-counter that times the blanked part of a map change.
// i_start loads the frame count; each i_tick afterwards decrements it and
// o_done pulses on the tick that consumes the last frame.
module ss_blank_timer #(
    parameter int FRAMES = 4
) (
    input  logic clk_75,
    input  logic reset,
    input  logic i_start,
    input  logic i_tick,
    output logic o_done
);
    localparam logic [3:0] LOAD = 4'(FRAMES);

    logic [3:0] r_count;

    // Load on start, otherwise count frames down to zero.
    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            r_count <= 4'd0;
        end else if (i_start) begin
            r_count <= LOAD;
        end else if (i_tick && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    // The start tick itself is not a blank frame.
    assign o_done = i_tick && !i_start && (r_count == 4'd1);

endmodule

// File: rtl/ss_map_sequencer.sv
// Map-segment sequencer: watches LocX once per frame, detects screen-edge
// crossings with hysteresis, blanks the screen for a few frames, then asks
// the player logic to reposition before re-arming.
// Optional feature macro: SS_MAP_SWITCH_OVERRIDE_EN (switch bank forces map_sel).
module ss_map_sequencer
    import ss_map_pkg::*;
#(
    parameter int         NUM_MAPS     = 3,
    parameter logic [7:0] EDGE_RIGHT   = 8'h7C,
    parameter logic [7:0] EDGE_LEFT    = 8'h00,
    parameter logic [7:0] REARM_MARGIN = 8'h08,
    parameter int         BLANK_FRAMES = 4
) (
    input  logic              clk_75,
    input  logic              reset,
    ss_map_sequencer_if.slave bus,
    output state_t            o_dbg_state
);
    localparam map_sel_t   MAX_MAP  = map_sel_t'(NUM_MAPS - 1);
    localparam logic [7:0] REARM_LO = EDGE_LEFT + REARM_MARGIN;
    localparam logic [7:0] REARM_HI = EDGE_RIGHT - REARM_MARGIN;

    state_t   r_state;
    map_sel_t r_map_sel;
    logic     r_wrap_dir;

    state_t   w_next_state;
    map_sel_t w_next_map;
    logic     w_next_dir;
    logic     w_start;
    logic     w_timer_done;
    logic     w_eval;
    logic     w_hit_right;
    logic     w_hit_left;
    logic     w_in_window;
    logic     w_changing;
    logic     w_req;

    assign w_eval      = bus.frame_tick && bus.loc_valid;
    assign w_hit_right = w_eval && (bus.LocX >= EDGE_RIGHT);
    assign w_hit_left  = w_eval && (bus.LocX == EDGE_LEFT);
    assign w_in_window = w_eval && (bus.LocX > REARM_LO) && (bus.LocX < REARM_HI);

`ifdef SS_MAP_SWITCH_OVERRIDE_EN
    logic w_unused_sw;
    assign w_unused_sw = ^bus.debounced_SW_75[14:2];
`else
    logic w_unused_sw;
    assign w_unused_sw = ^bus.debounced_SW_75;
`endif

    ss_blank_timer #(
        .FRAMES (BLANK_FRAMES)
    ) u_blank_timer (
        .clk_75  (clk_75),
        .reset   (reset),
        .i_start (w_start),
        .i_tick  (bus.frame_tick),
        .o_done  (w_timer_done)
    );

    // State, selected map and wrap direction registers.
    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            r_state    <= ARMED;
            r_map_sel  <= MAP_PART1;
            r_wrap_dir <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_map_sel  <= w_next_map;
            r_wrap_dir <= w_next_dir;
        end
    end

    // Next state: edge detection in ARMED, blank timing, wrap handshake, re-arm window.
    always_comb begin
        w_next_state = r_state;
        w_next_map   = r_map_sel;
        w_next_dir   = r_wrap_dir;
        w_start      = 1'b0;
        case (r_state)
            ARMED: begin
                // Right wins if a misconfiguration makes both edges hit at once.
                if (w_hit_right) begin
                    w_next_map   = (r_map_sel >= MAX_MAP) ? MAX_MAP : r_map_sel + 2'd1;
                    w_next_dir   = 1'b1;
                    w_next_state = BLANK;
                    w_start      = 1'b1;
                end else if (w_hit_left && (r_map_sel != MAP_PART1)) begin
                    w_next_map   = r_map_sel - 2'd1;
                    w_next_dir   = 1'b0;
                    w_next_state = BLANK;
                    w_start      = 1'b1;
                end
            end
            BLANK: begin
                if (w_timer_done) begin
                    w_next_state = WRAP;
                end
            end
            WRAP: begin
                if (bus.wrap_ack) begin
                    w_next_state = DISARMED;
                end
            end
            DISARMED: begin
                // Stay disarmed until the player has moved well away from both edges.
                if (w_in_window) begin
                    w_next_state = ARMED;
                end
            end
            default: begin
                w_next_state = ARMED;
            end
        endcase
`ifdef SS_MAP_SWITCH_OVERRIDE_EN
        if (bus.debounced_SW_75[15]) begin
            w_next_state = DISARMED;
            w_next_map   = clamp_map(bus.debounced_SW_75[1:0], NUM_MAPS);
            w_start      = 1'b0;
        end
`endif
    end

    // Outputs decoded from state: blank covers BLANK and WRAP, request only in WRAP.
    always_comb begin
        w_changing = 1'b0;
        w_req      = 1'b0;
        case (r_state)
            BLANK: begin
                w_changing = 1'b1;
            end
            WRAP: begin
                w_changing = 1'b1;
                w_req      = 1'b1;
            end
            default: begin
                w_changing = 1'b0;
                w_req      = 1'b0;
            end
        endcase
    end

    assign bus.map_sel      = r_map_sel;
    assign bus.map_changing = w_changing;
    assign bus.wrap_req     = w_req;
    assign bus.wrap_dir     = r_wrap_dir;
    assign bus.loop_active  = (r_map_sel == MAX_MAP);
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_ss_map_sequencer.sv
// Directed bench for ss_map_sequencer: edge crossings, hysteresis, wrap
// handshake, async reset and (with SS_MAP_SWITCH_OVERRIDE_EN) the switch override.
module tb_ss_map_sequencer;
    import ss_map_pkg::*;

    logic   clk_75;
    logic   reset;
    state_t dbg_state;
    int     tests;
    int     fails;

    ss_map_sequencer_if bus_if ();

    ss_map_sequencer u_dut (
        .clk_75      (clk_75),
        .reset       (reset),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    // Clock: 10 ns period.
    initial begin
        clk_75 = 1'b0;
        forever #5 clk_75 = ~clk_75;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame tick carrying LocX; returns on the following falling edge.
    task automatic tick(input logic [7:0] x, input logic valid);
        @(negedge clk_75);
        bus_if.frame_tick = 1'b1;
        bus_if.LocX       = x;
        bus_if.loc_valid  = valid;
        @(negedge clk_75);
        bus_if.frame_tick = 1'b0;
        bus_if.loc_valid  = 1'b1;
    endtask

    task automatic pulse_ack();
        @(negedge clk_75);
        bus_if.wrap_ack = 1'b1;
        @(negedge clk_75);
        bus_if.wrap_ack = 1'b0;
    endtask

    // Run out the blank frames, acknowledge the wrap and re-arm from mid-screen.
    task automatic finish_wrap();
        for (int i = 0; i < 4; i++) tick(8'h40, 1'b1);
        pulse_ack();
        tick(8'h40, 1'b1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus_if.frame_tick      = 1'b0;
        bus_if.LocX            = 8'h40;
        bus_if.loc_valid       = 1'b1;
        bus_if.wrap_ack        = 1'b0;
        bus_if.debounced_SW_75 = 16'h0000;
        repeat (3) @(negedge clk_75);

        // Reset state.
        check("rst_map_sel", 8'(bus_if.map_sel), 8'h0);
        check("rst_changing", 8'(bus_if.map_changing), 8'h0);
        check("rst_wrap_req", 8'(bus_if.wrap_req), 8'h0);
        check("rst_wrap_dir", 8'(bus_if.wrap_dir), 8'h0);
        check("rst_loop", 8'(bus_if.loop_active), 8'h0);
        check("rst_state", 8'(dbg_state), 8'(ARMED));
        reset = 1'b1;
        @(negedge clk_75);

        // Right crossing at exactly EDGE_RIGHT.
        tick(8'h7C, 1'b1);
        check("r1_map_sel", 8'(bus_if.map_sel), 8'h1);
        check("r1_changing", 8'(bus_if.map_changing), 8'h1);
        check("r1_wrap_req", 8'(bus_if.wrap_req), 8'h0);
        check("r1_wrap_dir", 8'(bus_if.wrap_dir), 8'h1);
        // wrap_ack during BLANK is ignored.
        pulse_ack();
        check("blank_ack_ign", 8'(dbg_state), 8'(BLANK));
        // loc_valid low does not stall the blank count.
        tick(8'h7C, 1'b1);
        tick(8'h7C, 1'b0);
        tick(8'h7C, 1'b0);
        check("blank3_req", 8'(bus_if.wrap_req), 8'h0);
        check("blank3_chg", 8'(bus_if.map_changing), 8'h1);
        tick(8'h7C, 1'b0);
        check("wrap_req_up", 8'(bus_if.wrap_req), 8'h1);
        check("wrap_dir_r", 8'(bus_if.wrap_dir), 8'h1);
        check("wrap_chg", 8'(bus_if.map_changing), 8'h1);
        repeat (3) @(negedge clk_75);
        check("wrap_req_hold", 8'(bus_if.wrap_req), 8'h1);
        pulse_ack();
        check("ack_req", 8'(bus_if.wrap_req), 8'h0);
        check("ack_chg", 8'(bus_if.map_changing), 8'h0);
        check("ack_state", 8'(dbg_state), 8'(DISARMED));
        check("ack_map", 8'(bus_if.map_sel), 8'h1);

        // Hysteresis: parked on the edge and on the window boundaries stays disarmed.
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b1);
        tick(8'h08, 1'b1);
        tick(8'h74, 1'b1);
        check("dis_state", 8'(dbg_state), 8'(DISARMED));
        check("dis_map", 8'(bus_if.map_sel), 8'h1);
        check("dis_chg", 8'(bus_if.map_changing), 8'h0);
        tick(8'h40, 1'b1);
        check("rearm_state", 8'(dbg_state), 8'(ARMED));
        tick(8'h00, 1'b1);
        check("l1_map_sel", 8'(bus_if.map_sel), 8'h0);
        check("l1_wrap_dir", 8'(bus_if.wrap_dir), 8'h0);
        check("l1_changing", 8'(bus_if.map_changing), 8'h1);
        finish_wrap();
        check("l1_rearm", 8'(dbg_state), 8'(ARMED));

        // Left edge on map 0 is ignored.
        for (int i = 0; i < 10; i++) tick(8'h00, 1'b1);
        check("m0_left_map", 8'(bus_if.map_sel), 8'h0);
        check("m0_left_chg", 8'(bus_if.map_changing), 8'h0);
        check("m0_left_state", 8'(dbg_state), 8'(ARMED));

        // Three right crossings: 0->1->2->2.
        tick(8'h7C, 1'b1);
        check("c1_map", 8'(bus_if.map_sel), 8'h1);
        check("c1_loop", 8'(bus_if.loop_active), 8'h0);
        finish_wrap();
        tick(8'h90, 1'b1);
        check("c2_map", 8'(bus_if.map_sel), 8'h2);
        check("c2_loop", 8'(bus_if.loop_active), 8'h1);
        finish_wrap();
        tick(8'hFF, 1'b1);
        check("c3_map", 8'(bus_if.map_sel), 8'h2);
        check("c3_loop", 8'(bus_if.loop_active), 8'h1);
        check("c3_chg", 8'(bus_if.map_changing), 8'h1);
        check("c3_dir", 8'(bus_if.wrap_dir), 8'h1);
        finish_wrap();

        // Async reset during BLANK on map 1.
        tick(8'h00, 1'b1);
        check("pre_rst_map", 8'(bus_if.map_sel), 8'h1);
        check("pre_rst_state", 8'(dbg_state), 8'(BLANK));
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_map", 8'(bus_if.map_sel), 8'h0);
        check("mid_rst_chg", 8'(bus_if.map_changing), 8'h0);
        check("mid_rst_req", 8'(bus_if.wrap_req), 8'h0);
        check("mid_rst_state", 8'(dbg_state), 8'(ARMED));
        @(negedge clk_75);
        reset = 1'b1;
        @(negedge clk_75);

`ifdef SS_MAP_SWITCH_OVERRIDE_EN
        // Switch override forces map_sel and suppresses edges.
        bus_if.debounced_SW_75 = 16'h8003;
        @(negedge clk_75);
        check("ovr_map_clamp", 8'(bus_if.map_sel), 8'h2);
        check("ovr_state", 8'(dbg_state), 8'(DISARMED));
        tick(8'h7C, 1'b1);
        check("ovr_edge_map", 8'(bus_if.map_sel), 8'h2);
        check("ovr_edge_chg", 8'(bus_if.map_changing), 8'h0);
        check("ovr_edge_req", 8'(bus_if.wrap_req), 8'h0);
        bus_if.debounced_SW_75 = 16'h8001;
        @(negedge clk_75);
        check("ovr_map1", 8'(bus_if.map_sel), 8'h1);
        bus_if.debounced_SW_75 = 16'h8003;
        @(negedge clk_75);
        bus_if.debounced_SW_75 = 16'h0000;
        tick(8'h00, 1'b1);
        check("rel_map", 8'(bus_if.map_sel), 8'h2);
        check("rel_state", 8'(dbg_state), 8'(DISARMED));
        tick(8'h40, 1'b1);
        check("rel_rearm", 8'(dbg_state), 8'(ARMED));
        tick(8'h00, 1'b1);
        check("rel_left_map", 8'(bus_if.map_sel), 8'h1);
        check("rel_left_dir", 8'(bus_if.wrap_dir), 8'h0);
`else
        // Without the override the switch bank has no effect.
        bus_if.debounced_SW_75 = 16'h8003;
        @(negedge clk_75);
        check("sw_ign_map", 8'(bus_if.map_sel), 8'h0);
        tick(8'h7C, 1'b1);
        check("sw_ign_edge", 8'(bus_if.map_sel), 8'h1);
        check("sw_ign_chg", 8'(bus_if.map_changing), 8'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
